hls_snn_deadlock_monitor_param: RTL

- Parametrised successor of the per-loop HLS deadlock monitors in the hls_snn co-simulation/debug layer.
- ORs a masked set of AXIS/FIFO block indications with child-monitor block outputs.
- Requires the condition to persist for a programmable number of cycles before flagging deadlock.
- Provides a sticky flag and a first-event source capture for post-mortem debug; instances chain hierarchically via inst_block_sigs.

---
 rtl/hls_snn_deadlock_pkg.sv | 24 ++
 rtl/hls_snn_deadlock_persist_cnt.sv | 60 ++++++
 rtl/hls_snn_deadlock_monitor_param.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/hls_snn_deadlock_pkg.sv
// ---------------------------------------------------------------------------
// hls_snn_deadlock_pkg
// Shared definitions for the parametrised hls_snn deadlock monitor:
//   - state_t            : monitor FSM state encoding (IDLE / COUNT / BLOCKED)
//   - DEFAULT_AXIS_MASK  : default participation mask for the six AXIS inputs
//   - cnt_width()        : width of a counter that must hold 0..limit
// ---------------------------------------------------------------------------
package hls_snn_deadlock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_BLOCKED = 2'd2
    } state_t;

    // Channels 0 and 1 are control-side streams that legitimately stall for
    // long periods, so they are excluded from deadlock detection by default.
    localparam logic [5:0] DEFAULT_AXIS_MASK = 6'b111100;

    function automatic int unsigned cnt_width(input int unsigned limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/hls_snn_deadlock_persist_cnt.sv
// ---------------------------------------------------------------------------
// hls_snn_deadlock_persist_cnt
// Saturating counter of consecutive cycles on which event_in was sampled high.
// Any low sample returns the count to zero. term is combinational and says
// "this edge will be (at least) the LIMIT-th consecutive high sample".
//
// Parameters:
//   LIMIT   saturation value / required run length (>= 1)
// Ports:
//   clock     in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   event_in  in   qualifying event for the current cycle
//   term      out  event_in high and run length reaches LIMIT at this edge
// ---------------------------------------------------------------------------
module hls_snn_deadlock_persist_cnt
    import hls_snn_deadlock_pkg::*;
#(
    parameter int unsigned LIMIT = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic event_in,
    output logic term
);

    localparam int unsigned CNT_W = cnt_width(LIMIT);

    // One extra bit so cnt+1 can never wrap before the compare.
    localparam logic [CNT_W:0] LIMIT_V = (CNT_W + 1)'(LIMIT);
    localparam logic [CNT_W:0] ONE_V   = (CNT_W + 1)'(1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W:0]   cnt_inc;
    logic             at_limit;

    assign cnt_inc  = {1'b0, cnt_reg} + ONE_V;
    assign at_limit = (cnt_inc >= LIMIT_V);
    assign term     = event_in && at_limit;

    always_comb begin
        cnt_next = cnt_reg;
        if (!event_in) begin
            cnt_next = '0;
        end else if (at_limit) begin
            cnt_next = LIMIT_V[CNT_W-1:0];
        end else begin
            cnt_next = cnt_inc[CNT_W-1:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/hls_snn_deadlock_monitor_param.sv
// ---------------------------------------------------------------------------
// hls_snn_deadlock_monitor_param
// Parametrised deadlock monitor for the hls_snn co-simulation/debug layer.
// A candidate condition (any participating AXIS channel blocked, or any child
// monitor blocked) must persist for PERSIST_CYCLES consecutive edges before
// block asserts. A sticky flag and a first-event source snapshot are kept for
// post-mortem debug. Instances chain by feeding block into a parent's
// inst_block_sigs.
//
// Build option:
//   HLS_SNN_DEADLOCK_IDLE_QUAL_EN  when defined, a fully idle instance set
//                                  (&inst_idle_sigs) suppresses the candidate;
//                                  otherwise inst_idle_sigs is ignored.
//
// Ports:
//   clock            in   rising-edge clock
//   reset            in   asynchronous active-high reset
//   axis_block_sigs  in   [N_AXIS] per-channel stream block indications
//   inst_idle_sigs   in   [N_INST] per-instance idle indications
//   inst_block_sigs  in   [N_SUB]  block outputs of child monitors
//   clear            in   synchronous clear of block_sticky / block_src
//   block            out  live deadlock indication (registered)
//   block_sticky     out  set on first block assertion, held until clear
//   block_src        out  [N_AXIS+N_SUB] {inst_block_sigs, masked axis}
//                         captured on first assertion
// ---------------------------------------------------------------------------
module hls_snn_deadlock_monitor_param
    import hls_snn_deadlock_pkg::*;
#(
    parameter int unsigned          N_AXIS         = 6,
    parameter int unsigned          N_INST         = 4,
    parameter int unsigned          N_SUB          = 1,
    parameter logic [N_AXIS-1:0]    AXIS_MASK      = DEFAULT_AXIS_MASK,
    parameter int unsigned          PERSIST_CYCLES = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_AXIS-1:0]       axis_block_sigs,
    input  logic [N_INST-1:0]       inst_idle_sigs,
    input  logic [N_SUB-1:0]        inst_block_sigs,
    input  logic                    clear,
    output logic                    block,
    output logic                    block_sticky,
    output logic [N_AXIS+N_SUB-1:0] block_src
);

    localparam int unsigned SRC_W = N_AXIS + N_SUB;

    // ------------------------------------------------------------------
    // Source reduction
    // ------------------------------------------------------------------
    logic [N_AXIS-1:0] masked_axis;
    logic [SRC_W-1:0]  src_vec;
    logic              raw_cand;
    logic              cand;

    // Masked-off channels are tied to zero so they can neither trigger the
    // monitor nor show up in the captured source vector.
    generate
        for (genvar gi = 0; gi < int'(N_AXIS); gi++) begin : g_mask
            if (AXIS_MASK[gi]) begin : g_on
                assign masked_axis[gi] = axis_block_sigs[gi];
            end else begin : g_off
                assign masked_axis[gi] = 1'b0;
            end
        end
    endgenerate

    assign src_vec  = {inst_block_sigs, masked_axis};
    assign raw_cand = |src_vec;

`ifdef HLS_SNN_DEADLOCK_IDLE_QUAL_EN
    // Every instance idle means nothing is waiting on anything: not a deadlock.
    assign cand = raw_cand && !(&inst_idle_sigs);
`else
    logic unused_idle;
    assign unused_idle = &inst_idle_sigs;
    assign cand        = raw_cand;
`endif

    // ------------------------------------------------------------------
    // Persistence counter
    // ------------------------------------------------------------------
    logic term;

    hls_snn_deadlock_persist_cnt #(
        .LIMIT    (PERSIST_CYCLES)
    ) u_persist_cnt (
        .clock    (clock),
        .reset    (reset),
        .event_in (cand),
        .term     (term)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    state_t state_reg;
    state_t state_next;

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (cand) begin
                    state_next = term ? ST_BLOCKED : ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (!cand) begin
                    state_next = ST_IDLE;
                end else if (term) begin
                    state_next = ST_BLOCKED;
                end
            end
            ST_BLOCKED: begin
                if (!cand) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    logic entering_blocked;
    assign entering_blocked = (state_next == ST_BLOCKED) && (state_reg != ST_BLOCKED);

    // ------------------------------------------------------------------
    // Sticky flag and first-event capture
    // ------------------------------------------------------------------
    logic             block_reg;
    logic             sticky_reg;
    logic             sticky_next;
    logic [SRC_W-1:0] src_reg;
    logic [SRC_W-1:0] src_next;

    // A new BLOCKED entry on the same edge as clear re-arms the capture, so
    // the snapshot then reflects the event that just happened.
    always_comb begin
        sticky_next = sticky_reg;
        src_next    = src_reg;
        if (entering_blocked && (!sticky_reg || clear)) begin
            sticky_next = 1'b1;
            src_next    = src_vec;
        end else if (clear) begin
            sticky_next = 1'b0;
            src_next    = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            block_reg  <= 1'b0;
            sticky_reg <= 1'b0;
            src_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            block_reg  <= (state_next == ST_BLOCKED);
            sticky_reg <= sticky_next;
            src_reg    <= src_next;
        end
    end

    assign block        = block_reg;
    assign block_sticky = sticky_reg;
    assign block_src    = src_reg;

endmodule
